// File: rtl/chip8_timer_access.sv
// CHIP-8 timer access unit: services Fx07/Fx15/Fx18 and generates the 60 Hz timer tick.
// Optional macro CHIP8_TIMER_TICK_EN enables the TICK_DIV clock divider; otherwise tick is always on.
module chip8_timer_access #(
  parameter int unsigned TICK_DIV = 16667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_x,
  input  logic [7:0] req_data,
  output logic       load_delay,
  output logic       load_sound,
  output logic [7:0] delay_in,
  output logic [7:0] sound_in,
  input  logic [7:0] delay_out,
  input  logic [7:0] sound_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_x,
  output logic [7:0] rsp_data,
  output logic       tick,
  output logic       beep,
  output logic       err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned X_W    = 4;

  localparam logic [1:0] OP_RD_DT = 2'b00;
  localparam logic [1:0] OP_WR_DT = 2'b01;
  localparam logic [1:0] OP_WR_ST = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              req_ready_d;
  logic              load_delay_d;
  logic              load_sound_d;
  logic [DATA_W-1:0] delay_in_d;
  logic [DATA_W-1:0] sound_in_d;
  logic              rsp_valid_d;
  logic [X_W-1:0]    rsp_x_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              err_d;
  logic              accept;

  assign accept = req_valid & req_ready;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d      = state_q;
    load_delay_d = 1'b0;
    load_sound_d = 1'b0;
    err_d        = 1'b0;
    delay_in_d   = delay_in;
    sound_in_d   = sound_in;
    rsp_valid_d  = rsp_valid;
    rsp_x_d      = rsp_x;
    rsp_data_d   = rsp_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_RD_DT: begin
              // Snapshot the timer now so later decrements cannot alter the reply.
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_x_d     = req_x;
              rsp_data_d  = delay_out;
            end
            OP_WR_DT: begin
              state_d      = LOAD;
              load_delay_d = 1'b1;
              delay_in_d   = req_data;
            end
            OP_WR_ST: begin
              state_d      = LOAD;
              load_sound_d = 1'b1;
              sound_in_d   = req_data;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b0;
      load_delay <= 1'b0;
      load_sound <= 1'b0;
      delay_in   <= '0;
      sound_in   <= '0;
      rsp_valid  <= 1'b0;
      rsp_x      <= '0;
      rsp_data   <= '0;
      err        <= 1'b0;
      beep       <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_ready  <= req_ready_d;
      load_delay <= load_delay_d;
      load_sound <= load_sound_d;
      delay_in   <= delay_in_d;
      sound_in   <= sound_in_d;
      rsp_valid  <= rsp_valid_d;
      rsp_x      <= rsp_x_d;
      rsp_data   <= rsp_data_d;
      err        <= err_d;
      beep       <= (sound_out != '0);
    end
  end

`ifdef CHIP8_TIMER_TICK_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;
  logic             tick_d;

  // Divider counts 0..TICK_DIV-1; tick is registered alongside the count it marks.
  always_comb begin
    div_d  = (div_q == CNT_W'(TICK_DIV - 1)) ? '0 : div_q + CNT_W'(1);
    tick_d = (div_d == CNT_W'(TICK_DIV - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else begin
      div_q <= div_d;
      tick  <= tick_d;
    end
  end
`else
  // No divider: the timer decrements every cycle; an out-of-range TICK_DIV parks tick low.
  localparam bit TICK_DIV_LEGAL = (TICK_DIV >= 2) && (TICK_DIV <= 65535);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= 1'b0;
    end else begin
      tick <= TICK_DIV_LEGAL;
    end
  end
`endif

endmodule

// File: tb/tb_chip8_timer_access.sv
// Directed bench for chip8_timer_access: read replies checked against a scoreboard queue.
module tb_chip8_timer_access;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_x;
  logic [7:0] req_data;
  logic       load_delay;
  logic       load_sound;
  logic [7:0] delay_in;
  logic [7:0] sound_in;
  logic [7:0] delay_out;
  logic [7:0] sound_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_x;
  logic [7:0] rsp_data;
  logic       tick;
  logic       beep;
  logic       err;

  int checks;
  int errors;
  logic [11:0] sb_q[$];

  chip8_timer_access #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_data   (req_data),
    .load_delay (load_delay),
    .load_sound (load_sound),
    .delay_in   (delay_in),
    .sound_in   (sound_in),
    .delay_out  (delay_out),
    .sound_out  (sound_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_x      (rsp_x),
    .rsp_data   (rsp_data),
    .tick       (tick),
    .beep       (beep),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive one request for a single cycle; reads record their expected reply.
  task automatic issue(input logic [1:0] op, input logic [3:0] x, input logic [7:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_data  = d;
    if (op == 2'b00) sb_q.push_back({x, delay_out});
    step();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for a reply, hold it for 'hold' extra cycles, then consume it.
  task automatic collect(input int hold, input string tag);
    logic [11:0] exp;
    int waited;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    check({tag, "_seen"}, 32'(rsp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    exp = sb_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_x"}, 32'(rsp_x), 32'(exp[11:8]));
      check({tag, "_data"}, 32'(rsp_data), 32'(exp[7:0]));
      if (i < hold) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic exp_tick;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_x     = 4'h0;
    req_data  = 8'h00;
    delay_out = 8'h00;
    sound_out = 8'h00;
    rsp_ready = 1'b0;

    step();
    step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_loads", 32'({load_delay, load_sound}), 32'd0);
    check("rst_data_in", 32'({delay_in, sound_in}), 32'd0);
    check("rst_rsp_data", 32'({rsp_x, rsp_data}), 32'd0);
    check("rst_flags", 32'({tick, beep, err}), 32'd0);

    reset = 1'b1;
    #1;
    check("rel_ready_pre_edge", 32'(req_ready), 32'd0);
    check("rel_tick_pre_edge", 32'(tick), 32'd0);

    for (int i = 1; i <= 12; i++) begin
      step();
`ifdef CHIP8_TIMER_TICK_EN
      exp_tick = ((i % 4) == 3);
`else
      exp_tick = 1'b1;
`endif
      check($sformatf("tick_c%0d", i), 32'(tick), 32'(exp_tick));
      check($sformatf("ready_c%0d", i), 32'(req_ready), 32'd1);
    end

    // Read DT, reply must be the value sampled at accept
    delay_out = 8'h3C;
    issue(2'b00, 4'd5, 8'h00);
    delay_out = 8'h3B;
    check("rd_latency", 32'(rsp_valid), 32'd1);
    check("rd_ready_low", 32'(req_ready), 32'd0);
    collect(3, "rd1");

    // Write DT
    issue(2'b01, 4'd0, 8'hA5);
    check("wdt_strobe", 32'(load_delay), 32'd1);
    check("wdt_value", 32'(delay_in), 32'hA5);
    check("wdt_no_sound", 32'(load_sound), 32'd0);
    check("wdt_ready_low", 32'(req_ready), 32'd0);
    step();
    check("wdt_strobe_end", 32'(load_delay), 32'd0);
    check("wdt_hold", 32'(delay_in), 32'hA5);
    check("wdt_ready_back", 32'(req_ready), 32'd1);

    // Write ST and beep lag
    issue(2'b10, 4'd0, 8'h02);
    check("wst_strobe", 32'(load_sound), 32'd1);
    check("wst_value", 32'(sound_in), 32'h02);
    check("wst_no_delay", 32'(load_delay), 32'd0);
    check("wst_dt_hold", 32'(delay_in), 32'hA5);
    step();
    check("wst_strobe_end", 32'(load_sound), 32'd0);
    check("beep_idle", 32'(beep), 32'd0);
    sound_out = 8'h02;
    step();
    check("beep_2", 32'(beep), 32'd1);
    sound_out = 8'h01;
    step();
    check("beep_1", 32'(beep), 32'd1);
    sound_out = 8'h00;
    step();
    check("beep_0", 32'(beep), 32'd0);

    // Reserved op
    issue(2'b11, 4'd7, 8'hFF);
    check("err_pulse", 32'(err), 32'd1);
    check("err_no_strobe", 32'({load_delay, load_sound}), 32'd0);
    check("err_no_rsp", 32'(rsp_valid), 32'd0);
    check("err_ready", 32'(req_ready), 32'd1);
    step();
    check("err_end", 32'(err), 32'd0);
    check("err_hold_in", 32'({delay_in, sound_in}), 32'hA502);

    // Back-to-back writes with valid held through LOAD
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 8'h11;
    step();
    check("b2b_w1", 32'({load_delay, delay_in}), 32'h111);
    req_data = 8'h22;
    step();
    check("b2b_gap", 32'({load_delay, req_ready}), 32'd1);
    step();
    check("b2b_w2", 32'({load_delay, delay_in}), 32'h122);
    req_valid = 1'b0;
    step();
    check("b2b_end", 32'(load_delay), 32'd0);

    // Back-to-back reads
    delay_out = 8'h44;
    issue(2'b00, 4'd2, 8'h00);
    collect(0, "rd2");
    delay_out = 8'h55;
    issue(2'b00, 4'd3, 8'h00);
    collect(0, "rd3");

    // Reset during RESP aborts the read
    delay_out = 8'h77;
    issue(2'b00, 4'd9, 8'h00);
    check("abort_pre_valid", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp", 32'({rsp_x, rsp_data}), 32'd0);
    check("abort_data_in", 32'({delay_in, sound_in}), 32'd0);
    check("abort_flags", 32'({req_ready, load_delay, load_sound, tick, beep, err}), 32'd0);
    sb_q.delete();
    step();
    step();
    check("abort_hold", 32'({rsp_valid, load_delay, load_sound}), 32'd0);
    reset = 1'b1;
    step();
    check("abort_rel_rsp", 32'(rsp_valid), 32'd0);
    delay_out = 8'h10;
    issue(2'b00, 4'd1, 8'h00);
    collect(0, "rd_post");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_timer_access.md
CHIP8_TIMER_ACCESS -- requirements
Module: chip8_timer_access

Interface
REQ-001 Parameter TICK_DIV, default 16667, clk cycles per 60 Hz timer tick (legal 2..65535).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 req_valid  in  1  CPU timer-access request present.
REQ-005 req_ready  out  1  high when unit accepts a request; transfer when req_valid & req_ready.
REQ-006 req_op  in  2  00 = read DT (Fx07), 01 = write DT (Fx15), 10 = write ST (Fx18), 11 = reserved.
REQ-007 req_x  in  4  register index Vx; req_data  in  8  Vx value for writes.
REQ-008 load_delay, load_sound  out  1 each; one-cycle load strobes to the timer.
REQ-009 delay_in, sound_in  out  8 each; load values to the timer.
REQ-010 delay_out, sound_out  in  8 each; current timer values.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_x  out  4; rsp_data  out  8  read response to the register file.
REQ-012 tick  out  1  timer decrement enable pulse; beep  out  1  sound active; err  out  1  reserved-op pulse.

Function
REQ-013 FSM states IDLE, LOAD, RESP; req_ready = 1 only in IDLE.
REQ-014 IDLE, accepted op 00: capture req_x and the delay_out value in the accept cycle; go to RESP next cycle.
REQ-015 IDLE, accepted op 01/10: latch req_data; next cycle state LOAD drives load_delay (01) or load_sound (10) high for exactly one cycle with delay_in/sound_in = latched data; then IDLE.
REQ-016 IDLE, accepted op 11: err high one cycle after accept, no strobe, no response, stay IDLE.
REQ-017 RESP: rsp_valid = 1 with rsp_x/rsp_data stable until rsp_valid & rsp_ready; then IDLE the next cycle.
REQ-018 Read latency: rsp_valid rises exactly 1 cycle after accept; write strobe exactly 1 cycle after accept.
REQ-019 rsp_data is the value sampled at accept; later timer decrements do not change it.
REQ-020 Read issued in same cycle a load strobe is active is impossible (req_ready = 0 in LOAD).
REQ-021 delay_in/sound_in hold their last loaded value when strobes are low; 0 after reset.
REQ-022 beep = registered (sound_out != 0), 1-cycle lag.
REQ-023 Strobe and tick coinciding: both asserted as computed; the timer gives load priority.
REQ-024 Back-to-back: new request acceptable the cycle after return to IDLE; minimum read throughput 1 per 3 cycles, write 1 per 2.

Reset
REQ-025 While reset = 0: state IDLE, req_ready 1 after release only, all strobes/rsp_valid/err/beep/tick 0, all data outputs 0, divider counter 0.
REQ-026 Reset asserted mid-transaction aborts it with no strobe or response emitted afterward.
REQ-027 First action after reset release is no earlier than the first rising clk edge with reset = 1.

Configuration
REQ-028 Macro CHIP8_TIMER_TICK_EN defined: internal counter 0..TICK_DIV-1, tick high one cycle when counter = TICK_DIV-1, counter wraps to 0.
REQ-029 CHIP8_TIMER_TICK_EN undefined: no counter; tick is 1 every cycle after reset release.

Verification
REQ-030 Read: delay_out = 0x3C, req op 00 x = 5 accepted -> next cycle rsp_valid = 1, rsp_x = 5, rsp_data = 0x3C; held 3 cycles with rsp_ready = 0, then consumed -> IDLE.
REQ-031 Write DT: op 01 data 0xA5 -> load_delay high one cycle, delay_in = 0xA5, 1 cycle after accept; load_sound stays 0.
REQ-032 Write ST 0x02 then sound_out counts 2,1,0 -> beep 1,1,0 with 1-cycle lag; op 11 -> err pulse, no strobe.
REQ-033 With CHIP8_TIMER_TICK_EN and TICK_DIV = 4: tick pulses at cycles 3, 7, 11 after release; without macro tick constantly 1.
REQ-034 reset driven 0 during RESP -> rsp_valid 0 immediately, outputs all 0; after release, read of delay_out = 0x10 returns 0x10.
